// File: rtl/mac_sequencer.sv
// Job sequencer for an external MAC: clears the accumulator, streams len operand
// pairs with a one-cycle enable-to-operand skew, then captures the rounded result.
`timescale 1ns/1ps
module mac_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic [2:0]  rnd_sel,
  input  logic        abort,
  input  logic        op_valid,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_c,
  output logic        op_ready,
  output logic        mac_op,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_c,
  output logic [2:0]  mac_sel,
  output logic        mac_clr,
  input  logic [15:0] mac_dout,
  output logic        busy,
  output logic        res_valid,
  output logic [15:0] res_data,
  input  logic        res_ready
);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  len_q;
  logic [2:0]  sel_q;
  logic [7:0]  a_q;
  logic [7:0]  c_q;
  logic        last_q;
  logic [1:0]  drain_q;
  logic        xfer;
  logic [7:0]  cnt_inc;

  assign xfer    = op_valid & op_ready;
  assign cnt_inc = cnt + 8'd1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      sel_q     <= '0;
      a_q       <= '0;
      c_q       <= '0;
      last_q    <= 1'b0;
      drain_q   <= '0;
      op_ready  <= 1'b0;
      mac_op    <= 1'b0;
      mac_a     <= '0;
      mac_c     <= '0;
      mac_sel   <= '0;
      mac_clr   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      mac_clr <= 1'b0;
      mac_op  <= 1'b0;
      mac_sel <= '0;
      // Second pipeline stage: operands follow the enable by one cycle.
      if (mac_op && !abort) begin
        mac_a   <= a_q;
        mac_c   <= c_q;
        mac_sel <= last_q ? sel_q : 3'b000;
      end
      if (abort && state != IDLE) begin
        state     <= IDLE;
        op_ready  <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len_q   <= len;
              sel_q   <= rnd_sel;
              cnt     <= '0;
              mac_clr <= 1'b1;
              state   <= CLR;
            end
          end
          CLR: begin
            if (len_q == 8'd0) begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              op_ready <= 1'b1;
              state    <= FEED;
            end
          end
          FEED: begin
            if (xfer) begin
              cnt    <= cnt_inc;
              mac_op <= 1'b1;
              a_q    <= op_a;
              c_q    <= op_c;
              last_q <= (cnt_inc == len_q);
              if (cnt_inc == len_q) begin
                op_ready <= 1'b0;
                drain_q  <= '0;
                state    <= DRAIN;
              end
            end
          end
          DRAIN: begin
            // Covers enable, operand and MAC-output cycles of the final pair.
            if (drain_q == 2'd2) begin
              res_data  <= mac_dout;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              drain_q <= drain_q + 2'd1;
            end
          end
          DONE: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a behavioural MAC drives mac_dout, jobs are checked
// against sum-of-products arithmetic and the pulse/select rules.
`timescale 1ns/1ps
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [2:0]  rnd_sel;
  logic        abort;
  logic        op_valid;
  logic [7:0]  op_a;
  logic [7:0]  op_c;
  logic        op_ready;
  logic        mac_op;
  logic [7:0]  mac_a;
  logic [7:0]  mac_c;
  logic [2:0]  mac_sel;
  logic        mac_clr;
  logic [15:0] mac_dout;
  logic        busy;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;

  int checks = 0;
  int errors = 0;

  mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .rnd_sel(rnd_sel),
    .abort(abort), .op_valid(op_valid), .op_a(op_a), .op_c(op_c),
    .op_ready(op_ready), .mac_op(mac_op), .mac_a(mac_a), .mac_c(mac_c),
    .mac_sel(mac_sel), .mac_clr(mac_clr), .mac_dout(mac_dout), .busy(busy),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: accumulates on the cycle after its enable, +16 when sel=100.
  logic signed [19:0] acc;
  logic signed [19:0] prod;
  logic               opd;
  assign prod     = $signed(mac_a) * $signed(mac_c);
  assign mac_dout = acc[19:4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      opd <= 1'b0;
    end else begin
      opd <= mac_op;
      if (mac_clr) acc <= '0;
      else if (opd) acc <= acc + prod + ((mac_sel == 3'b100) ? 20'sd16 : 20'sd0);
    end
  end

  // Event monitor, sampled mid-cycle.
  int         mon_op   = 0;
  int         mon_clr  = 0;
  int         mon_viol = 0;
  logic       op_pend  = 1'b0;
  logic       xfer_d   = 1'b0;
  logic [2:0] selq[$];
  always @(negedge clk) begin
    if (mac_op) mon_op <= mon_op + 1;
    if (mac_clr) mon_clr <= mon_clr + 1;
    if (mac_op && !xfer_d) mon_viol <= mon_viol + 1;
    if (op_pend) selq.push_back(mac_sel);
    op_pend <= mac_op;
    xfer_d  <= op_valid & op_ready;
  end

  logic signed [7:0] pa[$];
  logic signed [7:0] pc[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int n);
    pa.delete();
    pc.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back(8'($urandom));
      pc.push_back(8'($urandom));
    end
  endtask

  // vmode: 0 valid held high, 1 toggling 1,0,..., 2 random.
  task automatic run_job(input int n, input logic [2:0] rs, input int vmode,
                         input int hold, output logic [15:0] res);
    int idx, cyc, lat, op0, clr0, sel0, viol0, s;
    logic [31:0] sv;
    logic [15:0] exp_res;
    logic [15:0] held;
    op0   = mon_op;
    clr0  = mon_clr;
    viol0 = mon_viol;
    sel0  = selq.size();
    s = (rs == 3'b100) ? 16 : 0;
    for (int i = 0; i < n; i++) s += int'(pa[i]) * int'(pc[i]);
    sv = s;
    exp_res = sv[19:4];
    len = 8'(n);
    rnd_sel = rs;
    start = 1'b1;
    step();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      case (vmode)
        0:       op_valid = 1'b1;
        1:       op_valid = (cyc % 2 == 0);
        default: op_valid = 1'($urandom);
      endcase
      op_a = pa[idx];
      op_c = pc[idx];
      @(negedge clk);
      if (op_valid && op_ready) idx++;
      step();
      cyc++;
    end
    op_valid = 1'b0;
    chk("pairs_accepted", idx, n);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 40);
    chk("res_latency", lat, (n == 0) ? 2 : 4);
    chk("res_data", res_data, exp_res);
    res = res_data;
    chk("mac_op_count", mon_op - op0, n);
    chk("mac_clr_count", mon_clr - clr0, 1);
    chk("mac_op_without_xfer", mon_viol - viol0, 0);
    chk("operand_cycles", selq.size() - sel0, n);
    for (int i = sel0; i < selq.size(); i++)
      chk("mac_sel", selq[i], (i == selq.size() - 1) ? rs : 3'b000);
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      step();
      @(negedge clk);
      chk("res_valid_hold", res_valid, 1);
      chk("res_data_hold", res_data, held);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    start = 1'b1;
    step();
    res_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_consume", busy, 0);
    chk("res_valid_cleared", res_valid, 0);
  endtask

  logic [15:0] r;
  int          bad;

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; rnd_sel = '0; abort = 1'b0;
    op_valid = 1'b0; op_a = '0; op_c = '0; res_ready = 1'b0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_outputs", {op_ready, mac_op, mac_clr, res_valid, mac_sel}, 0);
    chk("reset_data", {mac_a, mac_c, res_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    pa = {8'sd2, -8'sd4, 8'sd7};
    pc = {8'sd3, 8'sd5, 8'sd7};
    run_job(3, 3'b000, 0, 0, r);
    chk("three_pair_result", r, 2);

    pa = {8'sd5};
    pc = {8'sd8};
    run_job(1, 3'b100, 0, 0, r);
    chk("single_rounded", r, 3);
    run_job(1, 3'b000, 0, 0, r);
    chk("single_unrounded", r, 2);

    fill_random(4);
    run_job(4, 3'b100, 1, 2, r);

    run_job(0, 3'b011, 0, 10, r);
    chk("zero_len_result", r, 0);

    // Abort on the second transfer of a five-pair job.
    fill_random(5);
    len = 8'd5;
    rnd_sel = 3'b100;
    start = 1'b1;
    step();
    start = 1'b0;
    op_valid = 1'b1;
    op_a = pa[0];
    op_c = pc[0];
    step();
    step();
    op_a = pa[1];
    op_c = pc[1];
    abort = 1'b1;
    @(negedge clk);
    chk("abort_on_transfer", op_ready & op_valid, 1);
    step();
    abort = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_outputs", {op_ready, mac_op, res_valid, mac_clr}, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      if (res_valid || busy) bad++;
    end
    chk("abort_no_result", bad, 0);
    fill_random(3);
    run_job(3, 3'b000, 0, 0, r);

    // Asynchronous reset mid-FEED.
    fill_random(5);
    len = 8'd5;
    rnd_sel = 3'b100;
    start = 1'b1;
    step();
    start = 1'b0;
    op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_a = pa[i];
      op_c = pc[i];
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {op_ready, mac_op, mac_clr, res_valid, mac_sel}, 0);
    chk("rst_data", {mac_a, mac_c, res_data}, 0);
    op_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step();
    fill_random(2);
    run_job(2, 3'b100, 0, 0, r);

    for (int j = 0; j < 8; j++) begin
      int n;
      n = int'($urandom_range(1, 12));
      fill_random(n);
      run_job(n, 3'($urandom_range(0, 7)), 2, int'($urandom_range(0, 3)), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have these ports (clock and reset first), name / direction / width / meaning:
REQ-002 clk  input  1  single clock, all state on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  job request, sampled in IDLE only.
REQ-005 len  input  8  operand-pair count for the job, latched on accepted start.
REQ-006 rnd_sel  input  3  rounding select for the MAC, latched on accepted start.
REQ-007 abort  input  1  cancel the current job.
REQ-008 op_valid  input  1  operand pair available.
REQ-009 op_a, op_c  input  8 each  signed operand pair.
REQ-010 op_ready  output  1  sequencer accepts a pair this cycle.
REQ-011 mac_op  output  1  MAC enable.
REQ-012 mac_a, mac_c  output  8 each  MAC operands.
REQ-013 mac_sel  output  3  MAC rounding select.
REQ-014 mac_clr  output  1  MAC accumulator clear pulse.
REQ-015 mac_dout  input  16  MAC result (accumulator bits [19:4]).
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 res_valid  output  1  result available.
REQ-018 res_data  output  16  signed result.
REQ-019 res_ready  input  1  result consumed.

Function
REQ-020 States SHALL be IDLE, CLR, FEED, DRAIN and DONE.
REQ-021 IDLE SHALL go to CLR when start=1; start SHALL be ignored in every other state.
REQ-022 CLR SHALL last 1 cycle with mac_clr=1, then go to FEED; if the latched len=0 it SHALL go to DONE with res_data=0.
REQ-023 In FEED, op_ready SHALL be 1 while fewer than len pairs have been accepted; a pair is transferred when op_valid&op_ready.
REQ-024 A transfer in cycle k SHALL produce mac_op=1 in cycle k+1, and mac_a/mac_c holding that pair in cycle k+2.
REQ-025 mac_a/mac_c SHALL hold their last values otherwise.
REQ-026 mac_op SHALL be 0 in any cycle with no transfer in the previous cycle; bubbles are legal.
REQ-027 mac_sel SHALL be 3'b000 during operand cycles of non-final pairs; during the final pair's operand cycle it SHALL equal the latched rnd_sel, so rounding is applied only on the final accumulation.
REQ-028 The accepted-pair counter SHALL be 8 bits, count 0..len, and never wrap.
REQ-029 FEED SHALL go to DRAIN on the len-th transfer.
REQ-030 DRAIN SHALL last until the final pair's operand cycle (k+2) has ended.
REQ-031 res_data SHALL capture mac_dout in cycle k+3, where k is the final transfer cycle; the state SHALL then go to DONE.
REQ-032 In DONE, res_valid=1 and res_data SHALL be held stable until res_valid&res_ready, then the state SHALL go to IDLE.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with mac_op, op_ready, res_valid and mac_clr at 0 and no result produced.
REQ-034 abort SHALL take priority over start, transfers and res_ready in the same cycle.
REQ-035 res_valid&res_ready and start in the same cycle SHALL NOT start a new job; start is sampled only in IDLE.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, independent of clk.
REQ-037 During reset, all outputs (mac_a, mac_c, mac_sel, res_data, the counter and the latched len/rnd_sel) SHALL be 0.
REQ-038 A reset mid-job SHALL discard the job; after release, behaviour SHALL be as after power-up.

Verification
REQ-039 Pairs (2,3), (-4,5), (7,7), len=3, rnd_sel=000, op_valid held high -> 3 mac_op pulses, one mac_clr, res_data=2 (35>>4), res_valid 1 cycle after the DRAIN end.
REQ-040 Single pair (5,8), len=1, rnd_sel=100 -> mac_sel=100 on the operand cycle, res_data=3 (sum 40 plus 16, >>4); the same stimulus with rnd_sel=000 -> res_data=2.
REQ-041 len=4 with op_valid toggling 1,0,1,0,... -> mac_op pulses only after transfers, exactly 4 total, and the final-pair mac_sel rule holds.
REQ-042 len=0 -> CLR then DONE, res_data=0, no mac_op; with res_ready held low -> res_valid stays high and res_data stays stable for 10 cycles.
REQ-043 abort asserted on the 2nd transfer of len=5 -> IDLE next cycle, no res_valid; a following start runs a clean job with a fresh mac_clr.
REQ-044 rst_n pulsed low between clock edges during FEED -> outputs 0 immediately, IDLE, busy=0.
